// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: one digit enable per dwell slot, with
// per-slot blank time, 16-level PWM, optional hex decode and frame-synced buffer swap.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int DWELL_CYCLES   = 125000,
    parameter int BLANK_CYCLES   = 1250,
    parameter bit EN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [8*NUM_DIGITS-1:0] i_digits,
    input  logic                    i_mode,
    input  logic [NUM_DIGITS-1:0]   i_digit_mask,
    input  logic                    i_load,
    input  logic [3:0]              i_brightness,
    output logic [7:0]              o_data,
    output logic [NUM_DIGITS-1:0]   o_en,
    output logic [3:0]              o_digit_idx,
    output logic                    o_frame_start
);

    localparam int                    DW         = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0]         DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0]         BLANK_C    = DW'(BLANK_CYCLES);
    localparam logic [3:0]            IDX_LAST   = 4'(NUM_DIGITS - 1);
    localparam logic [7:0]            OFF_BYTE   = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] EN_OFF     = {NUM_DIGITS{EN_ACTIVE_LOW}};

    logic [DW-1:0]           dwell_q, dwell_d;
    logic [3:0]              idx_q, idx_d;
    logic [3:0]              pwm_q, pwm_d;
    logic [8*NUM_DIGITS-1:0] act_digits_q, act_digits_d, pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   act_mask_q, act_mask_d, pend_mask_q, pend_mask_d;
    logic                    act_mode_q, act_mode_d, pend_mode_q, pend_mode_d;
    logic                    pend_q, pend_d;
    logic                    armed_q, armed_d;
    logic [7:0]              data_q, data_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [3:0]              idx_out_q;
    logic                    frame_q, frame_d;

    logic                    slot_end, frame_end, in_blank, lit, cur_mask;
    logic [7:0]              cur_byte;
    logic [7:0]              act_bytes [NUM_DIGITS];

    function automatic logic [7:0] hex_to_seg(input logic [7:0] b);
        logic [6:0] s;
        case (b[3:0])
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return {b[7], s} ^ {8{SEG_ACTIVE_LOW}};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_bytes
            assign act_bytes[gi] = act_digits_q[8*gi +: 8];
        end
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (dwell_q < BLANK_C);
        end
    endgenerate

    // Counters and double buffer
    always_comb begin
        slot_end      = (dwell_q == DWELL_LAST);
        frame_end     = slot_end && (idx_q == IDX_LAST);
        dwell_d       = slot_end ? '0 : dwell_q + 1'b1;
        idx_d         = idx_q;
        if (slot_end) idx_d = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
        // PWM phase restarts on the first ON cycle of every slot
        pwm_d         = (dwell_d == BLANK_C) ? 4'd0 : pwm_q + 4'd1;
        armed_d       = armed_q | frame_end;
        act_digits_d  = act_digits_q;
        act_mask_d    = act_mask_q;
        act_mode_d    = act_mode_q;
        pend_digits_d = pend_digits_q;
        pend_mask_d   = pend_mask_q;
        pend_mode_d   = pend_mode_q;
        pend_d        = pend_q;
        if (i_load && frame_end) begin
            act_digits_d = i_digits;
            act_mask_d   = i_digit_mask;
            act_mode_d   = i_mode;
            pend_d       = 1'b0;
        end else begin
            if (frame_end && pend_q) begin
                act_digits_d = pend_digits_q;
                act_mask_d   = pend_mask_q;
                act_mode_d   = pend_mode_q;
                pend_d       = 1'b0;
            end
            if (i_load) begin
                pend_digits_d = i_digits;
                pend_mask_d   = i_digit_mask;
                pend_mode_d   = i_mode;
                pend_d        = 1'b1;
            end
        end
    end

    // Output next-state
    always_comb begin
        cur_byte = 8'h00;
        cur_mask = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == 4'(k)) begin
                cur_byte = act_bytes[k];
                cur_mask = act_mask_q[k];
            end
        end
        lit = !in_blank && !cur_mask && ((i_brightness == 4'hF) || (pwm_q < i_brightness));
        en_d = EN_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (lit && (idx_q == 4'(k))) en_d[NUM_DIGITS-1-k] = !EN_ACTIVE_LOW;
        end
        if (in_blank || cur_mask) data_d = OFF_BYTE;
        else if (act_mode_q)      data_d = hex_to_seg(cur_byte);
        else                      data_d = cur_byte;
        frame_d = armed_q && (dwell_q == '0) && (idx_q == 4'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dwell_q       <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            act_digits_q  <= '0;
            act_mask_q    <= '0;
            act_mode_q    <= 1'b0;
            pend_digits_q <= '0;
            pend_mask_q   <= '0;
            pend_mode_q   <= 1'b0;
            pend_q        <= 1'b0;
            armed_q       <= 1'b0;
            data_q        <= OFF_BYTE;
            en_q          <= EN_OFF;
            idx_out_q     <= '0;
            frame_q       <= 1'b0;
        end else begin
            dwell_q       <= dwell_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            act_digits_q  <= act_digits_d;
            act_mask_q    <= act_mask_d;
            act_mode_q    <= act_mode_d;
            pend_digits_q <= pend_digits_d;
            pend_mask_q   <= pend_mask_d;
            pend_mode_q   <= pend_mode_d;
            pend_q        <= pend_d;
            armed_q       <= armed_d;
            data_q        <= data_d;
            en_q          <= en_d;
            idx_out_q     <= idx_q;
            frame_q       <= frame_d;
        end
    end

    assign o_data        = data_q;
    assign o_en          = en_q;
    assign o_digit_idx   = idx_out_q;
    assign o_frame_start = frame_q;

endmodule
